// File: rtl/padding_writer_gen.sv
// Padded IFM tile writer: walks the padded (H+2P) x (W+2P) grid in raster order
// (row, column, channel-word), emitting pad words at the border and forwarding
// producer words in the interior, one buffer word per write.
module padding_writer_gen #(
  parameter int DATA_W = 128,
  parameter int ELEM_W = 8,
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 11,
  parameter int PAD_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_c,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic [PAD_W-1:0]  cfg_pad,
  input  logic [3:0]        cfg_k,
  input  logic [ELEM_W-1:0] cfg_pad_val,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              line_ready,
  output logic [DIM_W-1:0]  line_idx
);

  localparam int LANES   = DATA_W / ELEM_W;
  localparam int LANE_SH = $clog2(LANES);
  // One extra bit so padded row/column indices never overflow.
  localparam int CNT_W   = DIM_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PAD = 2'd1, DATA = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  row, col, row_nxt, col_nxt;
  logic [DIM_W-1:0]  word, word_nxt;
  logic [ADDR_W-1:0] wcnt, wcnt_nxt;

  // Tile geometry captured at start; later cfg changes do not disturb the tile.
  logic [DIM_W-1:0]  wpp_m1;
  logic [CNT_W-1:0]  pad_l, h_lim, w_lim, row_last, col_last, k_l;
  logic [ELEM_W-1:0] pad_val_l;
  logic [ADDR_W-1:0] base_l;

  logic accept, wr_now, pad_now, last_word, last_col, tile_end;
  logic [DATA_W-1:0] pad_word;

  assign pad_word = {LANES{pad_val_l}};

  // Output comb: handshake, write decision and position flags for the current cell.
  always_comb begin
    accept    = (state == IDLE) && !busy && start;
    pad_now   = (state == PAD);
    in_ready  = (state == DATA);
    wr_now    = pad_now || (in_ready && in_valid);
    last_word = (word == wpp_m1);
    last_col  = (col == col_last);
    tile_end  = last_word && last_col && (row == row_last);
  end

  // Next-state comb: advance counters on each write and classify the next cell.
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    word_nxt  = word;
    wcnt_nxt  = wcnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (cfg_pad != '0) ? PAD : DATA;
          row_nxt   = '0;
          col_nxt   = '0;
          word_nxt  = '0;
          wcnt_nxt  = '0;
        end
      end
      default: begin
        if (wr_now) begin
          wcnt_nxt = wcnt + ADDR_W'(1);
          if (last_word) begin
            word_nxt = '0;
            if (last_col) begin
              col_nxt = '0;
              row_nxt = row + CNT_W'(1);
            end else begin
              col_nxt = col + CNT_W'(1);
            end
          end else begin
            word_nxt = word + DIM_W'(1);
          end
          if (tile_end) begin
            state_nxt = IDLE;
            row_nxt   = '0;
            col_nxt   = '0;
            word_nxt  = '0;
            wcnt_nxt  = '0;
          end else if ((row_nxt < pad_l) || (row_nxt >= h_lim) ||
                       (col_nxt < pad_l) || (col_nxt >= w_lim)) begin
            state_nxt = PAD;
          end else begin
            state_nxt = DATA;
          end
        end
      end
    endcase
  end

  // State register: FSM state and raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      word  <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      word  <= word_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Configuration capture on an accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      wpp_m1    <= (cfg_c >> LANE_SH) - DIM_W'(1);
      pad_l     <= CNT_W'(cfg_pad);
      h_lim     <= CNT_W'(cfg_h) + CNT_W'(cfg_pad);
      w_lim     <= CNT_W'(cfg_w) + CNT_W'(cfg_pad);
      row_last  <= CNT_W'(cfg_h) + CNT_W'({cfg_pad, 1'b0}) - CNT_W'(1);
      col_last  <= CNT_W'(cfg_w) + CNT_W'({cfg_pad, 1'b0}) - CNT_W'(1);
      k_l       <= CNT_W'(cfg_k);
      pad_val_l <= cfg_pad_val;
      base_l    <= base_addr;
    end
  end

  // Registered write port, completion/line pulses and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      line_ready <= 1'b0;
      line_idx   <= '0;
      busy       <= 1'b0;
    end else begin
      wr_en      <= wr_now;
      done       <= wr_now && tile_end;
      // Row r is usable by a k-tall window once r >= k-1.
      line_ready <= wr_now && last_word && last_col && ((row + CNT_W'(1)) >= k_l);
      if (wr_now) begin
        wr_addr <= base_l + wcnt;
        wr_data <= pad_now ? pad_word : data_in;
      end
      if (wr_now && last_word && last_col) begin
        line_idx <= DIM_W'(row);
      end
      // busy covers the done cycle so a start coincident with done is ignored.
      if (done) begin
        busy <= 1'b0;
      end else if (accept) begin
        busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_padding_writer_gen.sv
// Scoreboard bench for padding_writer_gen: stimulus pushes the expected write
// stream, a negedge monitor pops and compares every presented write.
module tb_padding_writer_gen;

  localparam int LANES = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [10:0]  cfg_c, cfg_w, cfg_h;
  logic [2:0]   cfg_pad;
  logic [3:0]   cfg_k;
  logic [7:0]   cfg_pad_val;
  logic [31:0]  base_addr;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         wr_en;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         busy, done, line_ready;
  logic [10:0]  line_idx;

  padding_writer_gen dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_c(cfg_c), .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_pad(cfg_pad),
    .cfg_k(cfg_k), .cfg_pad_val(cfg_pad_val), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .line_ready(line_ready), .line_idx(line_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         dn;
    logic         lr;
    logic [10:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int lr_seen = 0;
  int prod_n = 0;
  int prod_cyc = 0;
  int prod_mode = 0;
  int ir_low = 0;
  bit prod_en = 1'b0;
  logic prod_acc;
  logic [15:0] tag = 16'h0;

  function automatic logic [127:0] mkword(logic [15:0] t, int n);
    return {4{t, 16'(n)}};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected write stream for one tile, walked as a plain triple loop.
  task automatic push_expected(int c, int w, int h, int p, int k,
                               logic [7:0] pv, logic [31:0] base, logic [15:0] t);
    int wpp, wp, hp, n, idx, total;
    bit pad;
    exp_t e;
    wpp = c / LANES; wp = w + 2 * p; hp = h + 2 * p;
    total = hp * wp * wpp; n = 0; idx = 0;
    for (int r = 0; r < hp; r++)
      for (int cc = 0; cc < wp; cc++)
        for (int wd = 0; wd < wpp; wd++) begin
          pad = (r < p) || (r >= h + p) || (cc < p) || (cc >= w + p);
          e.addr = base + 32'(idx);
          e.data = pad ? {16{pv}} : mkword(t, n);
          if (!pad) n++;
          e.lr  = (cc == wp - 1) && (wd == wpp - 1) && (r >= k - 1);
          e.idx = 11'(r);
          e.dn  = (idx == total - 1);
          exp_q.push_back(e);
          idx++;
        end
  endtask

  task automatic launch(int c, int w, int h, int p, int k,
                        logic [7:0] pv, logic [31:0] base, logic [15:0] t);
    cfg_c = 11'(c); cfg_w = 11'(w); cfg_h = 11'(h); cfg_pad = 3'(p);
    cfg_k = 4'(k); cfg_pad_val = pv; base_addr = base;
    tag = t; prod_n = 0; prod_cyc = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns in the cycle where done is high; optionally pulses start mid-tile.
  task automatic wait_done(int bound, int pulse_at);
    int cyc;
    cyc = 0;
    while (!done && cyc < bound) begin
      if (cyc == pulse_at) begin
        start = 1'b1;
        base_addr = 32'h999;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_reached", 128'(done), 128'(1));
  endtask

  task automatic finish_tile(int c, int w, int h);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    chk("words_consumed", 128'(prod_n), 128'(w * h * (c / LANES)));
  endtask

  // Producer: offers word prod_n, advancing on each accepted handshake.
  initial begin
    in_valid = 1'b0;
    data_in  = '0;
    forever begin
      @(negedge clk);
      if (prod_en) begin
        prod_cyc++;
        in_valid = (prod_mode == 0) || (prod_cyc % 3 == 0);
        data_in  = mkword(tag, prod_n);
        if (busy && !in_ready && !done) ir_low++;
      end else begin
        in_valid = 1'b0;
      end
      prod_acc = in_valid && in_ready;
      @(posedge clk);
      if (prod_acc && !rst) prod_n++;
    end
  end

  // Monitor: every presented write is popped and compared.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual_addr=%h required=no write", wr_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 128'(wr_addr), 128'(mon_e.addr));
        chk("wr_data", wr_data, mon_e.data);
        chk("done_flag", 128'(done), 128'(mon_e.dn));
        chk("line_ready", 128'(line_ready), 128'(mon_e.lr));
        if (mon_e.lr) chk("line_idx", 128'(line_idx), 128'(mon_e.idx));
      end
    end else begin
      chk("pulse_without_write", 128'({done, line_ready}), 128'(0));
    end
    if (line_ready) lr_seen++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  int w0, l0, cyc;

  initial begin
    rst = 1'b1; start = 1'b0;
    cfg_c = 11'd16; cfg_w = 11'd2; cfg_h = 11'd2; cfg_pad = 3'd1;
    cfg_k = 4'd1; cfg_pad_val = 8'h00; base_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_wr_en", 128'(wr_en), 128'(0));
    chk("rst_wr_addr", 128'(wr_addr), 128'(0));
    chk("rst_wr_data", wr_data, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_line_idx", 128'(line_idx), 128'(0));

    // 1: 2x2, P=1, continuous valid; k=1 so every padded row pulses.
    prod_en = 1'b1; prod_mode = 0;
    w0 = wr_seen; l0 = lr_seen;
    push_expected(16, 2, 2, 1, 1, 8'h00, 32'h100, 16'hA001);
    launch(16, 2, 2, 1, 1, 8'h00, 32'h100, 16'hA001);
    wait_done(200, -1);
    chk("t1_busy_at_done", 128'(busy), 128'(1));
    @(posedge clk); #1;
    chk("t1_busy_after_done", 128'(busy), 128'(0));
    finish_tile(16, 2, 2);
    chk("t1_writes", 128'(wr_seen - w0), 128'(16));
    chk("t1_lines", 128'(lr_seen - l0), 128'(4));

    // 2: same tile with valid 1-of-3 cycles.
    prod_mode = 1;
    w0 = wr_seen;
    push_expected(16, 2, 2, 1, 1, 8'h00, 32'h100, 16'hA002);
    launch(16, 2, 2, 1, 1, 8'h00, 32'h100, 16'hA002);
    wait_done(400, -1);
    finish_tile(16, 2, 2);
    chk("t2_writes", 128'(wr_seen - w0), 128'(16));

    // 3: no padding, in_ready must stay high for the whole tile.
    prod_mode = 0; ir_low = 0;
    w0 = wr_seen;
    push_expected(32, 3, 2, 0, 1, 8'h5A, 32'h40, 16'hA003);
    launch(32, 3, 2, 0, 1, 8'h5A, 32'h40, 16'hA003);
    wait_done(200, -1);
    finish_tile(32, 3, 2);
    chk("t3_writes", 128'(wr_seen - w0), 128'(12));
    chk("t3_in_ready_low_cycles", 128'(ir_low), 128'(0));

    // 4: P=2, pad 0x80, k=3: rows 2..7 pulse.
    w0 = wr_seen; l0 = lr_seen;
    push_expected(16, 4, 4, 2, 3, 8'h80, 32'h1000, 16'hA004);
    launch(16, 4, 4, 2, 3, 8'h80, 32'h1000, 16'hA004);
    wait_done(400, -1);
    finish_tile(16, 4, 4);
    chk("t4_writes", 128'(wr_seen - w0), 128'(64));
    chk("t4_lines", 128'(lr_seen - l0), 128'(6));

    // 5: reset mid-tile, then restart from a new base.
    w0 = wr_seen;
    push_expected(16, 2, 2, 1, 1, 8'h00, 32'h100, 16'hA005);
    launch(16, 2, 2, 1, 1, 8'h00, 32'h100, 16'hA005);
    cyc = 0;
    while ((wr_seen - w0) < 7 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t5_reached_write7", 128'((wr_seen - w0) >= 7), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_wr_en", 128'(wr_en), 128'(0));
    chk("t5_wr_addr", 128'(wr_addr), 128'(0));
    chk("t5_wr_data", wr_data, 128'(0));
    chk("t5_busy", 128'(busy), 128'(0));
    chk("t5_done", 128'(done), 128'(0));
    chk("t5_line_ready", 128'(line_ready), 128'(0));
    chk("t5_line_idx", 128'(line_idx), 128'(0));
    chk("t5_in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;
    exp_q.delete();
    w0 = wr_seen;
    push_expected(16, 2, 2, 1, 1, 8'h00, 32'h200, 16'hA006);
    launch(16, 2, 2, 1, 1, 8'h00, 32'h200, 16'hA006);
    wait_done(200, -1);
    finish_tile(16, 2, 2);
    chk("t5_restart_writes", 128'(wr_seen - w0), 128'(16));

    // 6: start while busy ignored; start in done cycle ignored, next cycle accepted.
    w0 = wr_seen;
    push_expected(16, 2, 2, 1, 1, 8'h00, 32'h300, 16'hA007);
    launch(16, 2, 2, 1, 1, 8'h00, 32'h300, 16'hA007);
    wait_done(200, 4);
    chk("t6_first_consumed", 128'(prod_n), 128'(4));
    push_expected(16, 2, 2, 1, 1, 8'h11, 32'h400, 16'hA008);
    cfg_pad_val = 8'h11; base_addr = 32'h400; tag = 16'hA008;
    prod_n = 0; prod_cyc = 0;
    start = 1'b1;
    @(posedge clk); #1;
    chk("t6_start_at_done_ignored", 128'(busy), 128'(0));
    @(posedge clk); #1;
    start = 1'b0;
    chk("t6_start_next_accepted", 128'(busy), 128'(1));
    wait_done(200, -1);
    finish_tile(16, 2, 2);
    chk("t6_writes", 128'(wr_seen - w0), 128'(32));

    prod_en = 1'b0;
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
